// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light mode blocks and the display driver.
// Light codes and the fixed active-low segment patterns.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED       = 2'd0,
        YELLOW    = 2'd1,
        GREEN     = 2'd2,
        UNDEFINED = 2'd3
    } light_t;

    // Segment order is {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_Y     = 7'b0010001;
    localparam logic [6:0] SEG_G     = 7'b1000010;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low 7-segment code.
// A dash request overrides a blank request, and both override the value.
module seg7_decode
    import traffic_pkg::*;
(
    input  logic [3:0] val,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            case (val)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/light_display_driver.sv
// Drives the lamp LEDs and a 4-digit multiplexed 7-segment display from the
// active mode's light code, remaining time and mode number.
module light_display_driver
    import traffic_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] light,
    input  logic [4:0] lightTime,
    input  logic       feedback,
    input  logic [1:0] mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       ledR,
    output logic       ledY,
    output logic       ledG
);

    localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    light_t        l_q;
    logic [4:0]    t_q;
    logic [1:0]    m_q;
    logic          fb_q;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    dig;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    logic          fb_rise;
    logic [1:0]    tens;
    logic [3:0]    ones;
    logic          undef;
    logic [3:0]    dval;
    logic          dblank;
    logic          ddash;
    logic [6:0]    dseg;
    logic [6:0]    seg_nxt;
    logic          blink_en;
    logic          lamp_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_q  <= RED;
            t_q  <= '0;
            m_q  <= '0;
            fb_q <= 1'b0;
        end else begin
            l_q  <= light_t'(light);
            t_q  <= lightTime;
            m_q  <= mode;
            fb_q <= feedback;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            dig      <= 2'd0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig      <= dig + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign fb_rise = feedback & ~fb_q;

    // A phase-change restart takes priority over the free-running wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (fb_rise) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        if (t_q >= 5'd30)      tens = 2'd3;
        else if (t_q >= 5'd20) tens = 2'd2;
        else if (t_q >= 5'd10) tens = 2'd1;
        else                   tens = 2'd0;
        ones = 4'(t_q - 5'(tens) * 5'd10);
    end

    assign undef = (l_q == UNDEFINED);

    always_comb begin
        dval   = 4'd0;
        dblank = 1'b0;
        ddash  = 1'b0;
        case (dig)
            2'd0: begin
                dval  = ones;
                ddash = undef;
            end
            2'd1: begin
                dval   = {2'b00, tens};
                dblank = (tens == 2'd0);
                ddash  = undef;
            end
            2'd3:    dval = {2'b00, m_q};
            default: dval = 4'd0;
        endcase
    end

    seg7_decode u_dec (
        .val   (dval),
        .blank (dblank),
        .dash  (ddash),
        .seg   (dseg)
    );

    always_comb begin
        seg_nxt = dseg;
        if (dig == 2'd2) begin
            case (l_q)
                RED:     seg_nxt = SEG_R;
                YELLOW:  seg_nxt = SEG_Y;
                GREEN:   seg_nxt = SEG_G;
                default: seg_nxt = SEG_DASH;
            endcase
        end
    end

    assign blink_en = ((l_q == GREEN) || (l_q == YELLOW)) && (t_q <= 5'd3) && (t_q != 5'd0);
    assign lamp_on  = blink_en ? phase : 1'b1;

    // seg and an come from the same dig in the same cycle, so the frame never tears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg  <= SEG_BLANK;
            an   <= 4'hF;
            ledR <= 1'b0;
            ledY <= 1'b0;
            ledG <= 1'b0;
        end else begin
            seg  <= seg_nxt;
            an   <= ~(4'b0001 << dig);
            ledR <= (l_q == RED);
            ledY <= (l_q == YELLOW) && lamp_on;
            ledG <= (l_q == GREEN) && lamp_on;
        end
    end

endmodule

// File: tb/tb_light_display_driver.sv
// Randomized bench for light_display_driver with a cycle-level reference
// model built from scan/blink period arithmetic.
module tb_light_display_driver;

    localparam int SD = 4;
    localparam int BD = 8;

    logic       clk;
    logic       rst;
    logic [1:0] cur_l;
    logic [4:0] cur_t;
    logic       cur_fb;
    logic [1:0] cur_m;
    logic [6:0] seg;
    logic [3:0] an;
    logic       ledR, ledY, ledG;

    int ncmp = 0;
    int nerr = 0;

    // model state: edges since reset release, last restart edge, captured inputs
    int         n;
    int         r;
    int         cap_l, cap_t, cap_m;
    logic       fb_prev;
    logic [3:0] last_an;

    light_display_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk       (clk),
        .rst       (rst),
        .light     (cur_l),
        .lightTime (cur_t),
        .feedback  (cur_fb),
        .mode      (cur_m),
        .seg       (seg),
        .an        (an),
        .ledR      (ledR),
        .ledY      (ledY),
        .ledG      (ledG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit(input int v);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[v];
    endfunction

    function automatic logic [6:0] exp_seg(input int l, input int t, input int m, input int d);
        if (d == 3) return digit(m);
        if (l == 3) return 7'b0111111;
        if (d == 2) return (l == 0) ? 7'b0101111 : (l == 1) ? 7'b0010001 : 7'b1000010;
        if (d == 1) return (t / 10 == 0) ? 7'h7F : digit(t / 10);
        return digit(t % 10);
    endfunction

    function automatic logic [2:0] exp_led(input int l, input int t, input int ph);
        int on;
        on = ((l == 1 || l == 2) && t >= 1 && t <= 3) ? ph : 1;
        return {l == 0, (l == 1) && (on == 1), (l == 2) && (on == 1)};
    endfunction

    task automatic model_reset();
        n = 0; r = 0; cap_l = 0; cap_t = 0; cap_m = 0; fb_prev = 1'b0;
    endtask

    // One clk edge: predict, sample 1 time unit after the edge, then advance the model
    task automatic step();
        int d, ph;
        logic rise;
        logic [3:0] ea;
        logic [2:0] el;
        n++;
        d    = ((n - 1) / SD) % 4;
        ph   = 1 ^ (((n - r - 1) / BD) & 1);
        rise = cur_fb && !fb_prev;
        ea   = ~(4'b0001 << d);
        el   = exp_led(cap_l, cap_t, ph);
        @(posedge clk); #1;
        chk("an", 32'(an), 32'(ea));
        chk("seg", 32'(seg), 32'(exp_seg(cap_l, cap_t, cap_m, d)));
        chk("led", 32'({ledR, ledY, ledG}), 32'(el));
        last_an = ea;
        cap_l = int'(cur_l); cap_t = int'(cur_t); cap_m = int'(cur_m);
        fb_prev = cur_fb;
        if (rise) r = n;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic set_in(input int l, input int t, input int m);
        cur_l = 2'(l); cur_t = 5'(t); cur_m = 2'(m);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_an"}, 32'(an), 32'hF);
        chk({tag, "_led"}, 32'({ledR, ledY, ledG}), 32'h0);
    endtask

    initial begin
        int found;
        rst = 1'b1;
        cur_fb = 1'b0;
        set_in($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 3));
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            cur_fb = 1'($urandom_range(0, 1));
            set_in($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 3));
            chk_reset_vals("hold_rst");
        end
        cur_fb = 1'b0;
        #2 rst = 1'b0;

        set_in(2, 15, 3); run(24);
        set_in(0, 7, 1);  run(20);
        set_in(1, 3, 2);  run(13);
        cur_fb = 1'b1;    step();
        cur_fb = 1'b0;    run(30);
        set_in(2, 0, 0);  run(20);
        set_in(3, 22, 2); run(20);

        // async reset while the third digit is lit
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (last_an == 4'b1011) found = 1;
        end
        chk("wait_an_1011", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(posedge clk); #1;
        chk_reset_vals("async_hold");
        #2 rst = 1'b0;
        model_reset();
        run(8);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 23) == 0)
                set_in($urandom_range(0, 3),
                       ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : $urandom_range(0, 31),
                       $urandom_range(0, 3));
            cur_fb = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
